// File: rtl/exe_hazard_ctrl.sv
// Execute-stage sequencing: load-use/RAW stall, taken-branch flush window,
// and whole-pipe freeze while data memory is busy, with timeout and stall count.
module exe_hazard_ctrl #(
  parameter int FWD_EN      = 1,
  parameter int BR_PENALTY  = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        exe_wb_en,
  input  logic [3:0]  exe_dest,
  input  logic        exe_mem_r_en,
  input  logic        mem_wb_en,
  input  logic [3:0]  mem_dest,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        hold_if_id,
  output logic        bubble_exe,
  output logic        flush_if_id,
  output logic        flush_id_exe,
  output logic        freeze_all,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_MEM_WAIT} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(BR_PENALTY - 1);
  localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);
  localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

  state_t      r_state, r_state_next;
  state_t      r_saved_state, r_saved_state_next;
  state_t      w_eff_state;
  logic [2:0]  r_flush_cnt, r_flush_cnt_next;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_err;
  logic [15:0] r_stall_cnt;

  logic w_src1_ok, w_src2_ok, w_exe_match, w_mem_match, w_raw_hz, w_freeze;

  // PC (r15) is never a hazard source.
  assign w_src1_ok   = id_valid & (id_src1 != 4'hF);
  assign w_src2_ok   = id_valid & id_two_src & (id_src2 != 4'hF);
  assign w_exe_match = exe_wb_en & ((w_src1_ok & (id_src1 == exe_dest)) |
                                    (w_src2_ok & (id_src2 == exe_dest)));
  assign w_mem_match = mem_wb_en & ((w_src1_ok & (id_src1 == mem_dest)) |
                                    (w_src2_ok & (id_src2 == mem_dest)));
  assign w_raw_hz    = (FWD_EN != 0) ? (w_exe_match & exe_mem_r_en)
                                     : (w_exe_match | w_mem_match);
  assign w_freeze    = mem_req & ~mem_ready;

  // The cycle memory completes behaves as the state that was interrupted.
  assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_saved_state : r_state;

  always_comb begin
    hold_if_id         = 1'b0;
    bubble_exe         = 1'b0;
    flush_if_id        = 1'b0;
    flush_id_exe       = 1'b0;
    r_state_next       = r_state;
    r_saved_state_next = r_saved_state;
    r_flush_cnt_next   = r_flush_cnt;
    if (w_freeze) begin
      r_state_next = ST_MEM_WAIT;
      if (r_state != ST_MEM_WAIT) r_saved_state_next = r_state;
    end else begin
      r_state_next = w_eff_state;
      case (w_eff_state)
        ST_RUN: begin
          if (branch_taken) begin
            flush_if_id  = 1'b1;
            flush_id_exe = 1'b1;
            if (BR_PENALTY > 1) begin
              r_state_next     = ST_FLUSH;
              r_flush_cnt_next = FLUSH_INIT;
            end
          end else if (w_raw_hz) begin
            hold_if_id = 1'b1;
            bubble_exe = 1'b1;
          end
        end
        ST_FLUSH: begin
          flush_if_id      = 1'b1;
          flush_id_exe     = 1'b1;
          r_flush_cnt_next = r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1) r_state_next = ST_RUN;
        end
        default: r_state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_saved_state <= ST_RUN;
      r_flush_cnt   <= 3'd0;
      r_wait_cnt    <= 8'd0;
      r_mem_err     <= 1'b0;
      r_stall_cnt   <= 16'd0;
    end else begin
      r_state       <= r_state_next;
      r_saved_state <= r_saved_state_next;
      r_flush_cnt   <= r_flush_cnt_next;
      if (!w_freeze)
        r_wait_cnt <= 8'd0;
      else if (r_wait_cnt != TIMEOUT)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      // Freeze keeps going after a timeout; only the sticky flag reports it.
      if (w_freeze && (r_wait_cnt == TIMEOUT_M1))
        r_mem_err <= 1'b1;
      if (hold_if_id && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign freeze_all = w_freeze;
  assign mem_err    = r_mem_err;
  assign stall_cnt  = r_stall_cnt;

endmodule
